riscv_fetch_unit: RTL and testbench

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// In-order instruction fetch unit: issues sequential requests, buffers responses in a FIFO, handles redirects.
// Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets instead of silently aligning them.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4,
  output logic        fetch_misaligned
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [31:0]   fifo_inst_d [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [OW-1:0] occ_s;
  logic          req_fire_s;
  logic          rsp_fire_s;
  logic          push_s;
  logic          pop_s;
  logic          halted_s;
  logic [31:0]   rsp_pc_s;
  logic [31:0]   redir_tgt_s;

  assign imem_req_addr = fetch_pc_q;

  // Handshakes; requests are gated so every in-flight response already owns a FIFO slot.
  always_comb begin
    occ_s          = OW'(count_q) + OW'(inflight_q);
    imem_req_valid = rst_n && !halted_s && (occ_s < OW'(FIFO_DEPTH));
    req_fire_s     = imem_req_valid && imem_req_ready;
    rsp_fire_s     = imem_rsp_valid && (inflight_q != '0);
    push_s         = rsp_fire_s && (drop_q == '0) && !redirect_valid;
    pop_s          = (count_q != '0) && if_ready && !redirect_valid;
    // With nothing left to drop, the oldest outstanding request was issued inflight words ago.
    rsp_pc_s       = fetch_pc_q - (32'(inflight_q) << 2);
  end

  // Next-state logic; a redirect overrides every other update in its cycle.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_d      = drop_q;
    case ({req_fire_s, rsp_fire_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redir_tgt_s;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_d     = inflight_d;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_fire_s && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        fifo_inst_d[wr_ptr_q] = imem_rsp_data;
        fifo_pc_d[wr_ptr_q]   = rsp_pc_s;
        wr_ptr_d              = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head-of-buffer outputs, forced to zero while empty.
  always_comb begin
    if (count_q != '0) begin
      if_valid = 1'b1;
      if_inst  = fifo_inst_q[rd_ptr_q];
      if_pc    = fifo_pc_q[rd_ptr_q];
      if_pc_4  = fifo_pc_q[rd_ptr_q] + 32'd4;
    end else begin
      if_valid = 1'b0;
      if_inst  = 32'h0000_0000;
      if_pc    = 32'h0000_0000;
      if_pc_4  = 32'h0000_0000;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]   <= 32'h0000_0000;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;
  logic misaligned_q, misaligned_d;

  assign redir_tgt_s      = redirect_pc;
  assign halted_s         = halted_q;
  assign fetch_misaligned = misaligned_q;

  // Any redirect re-evaluates the trap: misaligned sets it, aligned clears it.
  always_comb begin
    if (redirect_valid) begin
      halted_d     = (redirect_pc[1:0] != 2'b00);
      misaligned_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      halted_d     = halted_q;
      misaligned_d = misaligned_q;
    end
  end

  // Trap state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end
`else
  logic unused_redir_lsb_s;

  assign redir_tgt_s        = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb_s = |redirect_pc[1:0];
  assign halted_s           = 1'b0;
  assign fetch_misaligned   = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: 1-cycle memory model plus a scoreboard of expected decode-side entries.
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .if_pc_4(if_pc_4),
    .fetch_misaligned(fetch_misaligned)
  );

  typedef struct {
    logic [31:0] mem_addr;
    logic [31:0] pc;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_fire = 0;
  int          first_fire_cyc = -1;
  int          first_valid_cyc = -1;
  int          base;
  logic [31:0] exp_addr = 32'h0000_0000;
  bit          mis_m = 1'b0;
  bit          halted_m = 1'b0;
  bit          rdy = 1'b0, ird = 1'b0, redir = 1'b0, hold = 1'b0, spur = 1'b0;
  logic [31:0] redir_pc = 32'h0000_0000;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, update the models, advance.
  task automatic step();
    bit   rsp_now;
    bit   fire;
    req_t r;
    imem_req_ready = rdy;
    if_ready       = ird;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    rsp_now        = !hold && (pend.size() != 0);
    imem_rsp_valid = rsp_now || (spur && (pend.size() == 0));
    imem_rsp_data  = rsp_now ? inst_of(pend[0].mem_addr) : 32'hDEAD_BEEF;
    #1;
    if (exp_q.size() != 0) begin
      check("if_valid", 32'(if_valid), 32'd1);
      check("if_pc", if_pc, exp_q[0]);
      check("if_inst", if_inst, inst_of(exp_q[0]));
      check("if_pc_4", if_pc_4, exp_q[0] + 32'd4);
    end else begin
      check("if_valid_empty", 32'(if_valid), 32'd0);
      check("if_zero_when_empty", if_inst | if_pc | if_pc_4, 32'd0);
    end
    check("fetch_misaligned", 32'(fetch_misaligned), 32'(mis_m));
    if (halted_m) check("halt_no_req", 32'(imem_req_valid), 32'd0);
    if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    fire = imem_req_valid && rdy;
    if (fire) begin
      check("req_addr", imem_req_addr, exp_addr);
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
    end
    if (ird && !redir && exp_q.size() != 0) void'(exp_q.pop_front());
    if (rsp_now) begin
      r = pend.pop_front();
      if (!r.stale && !redir) exp_q.push_back(r.pc);
    end
    if (fire) begin
      r.mem_addr = imem_req_addr;
      r.pc       = exp_addr;
      r.stale    = redir;
      pend.push_back(r);
      n_fire++;
      exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      for (int i = 0; i < pend.size(); i++) begin
        r = pend[i];
        r.stale = 1'b1;
        pend[i] = r;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_m    = (redir_pc[1:0] != 2'b00);
      halted_m = (redir_pc[1:0] != 2'b00);
      exp_addr = redir_pc;
`else
      exp_addr = {redir_pc[31:2], 2'b00};
`endif
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_zero", if_inst | if_pc | if_pc_4, 32'd0);
    check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
    pend.delete();
    exp_q.delete();
    exp_addr        = 32'h0000_0000;
    mis_m           = 1'b0;
    halted_m        = 1'b0;
    n_fire          = 0;
    first_fire_cyc  = -1;
    first_valid_cyc = -1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    rdy = 1'b0; ird = 1'b1; redir = 1'b0; hold = 1'b0; spur = 1'b0;
    for (int i = 0; i < 40 && (pend.size() != 0 || exp_q.size() != 0 || if_valid); i++) step();
    check("drain_if_valid", 32'(if_valid), 32'd0);
  endtask

  initial begin
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Sequential fetch from reset with a 1-cycle memory.
    rdy = 1'b1; ird = 1'b1;
    repeat (12) step();
    check("first_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd2);
    check("first_fire_cycle_seen", 32'(first_fire_cyc >= 0), 32'd1);

    // Decode stalled: buffer fills, then one pop frees exactly one request.
    do_reset();
    rdy = 1'b1; ird = 1'b0;
    repeat (10) step();
    check("fill_reqs", 32'(n_fire), 32'd4);
    check("fill_stall", 32'(imem_req_valid), 32'd0);
    ird = 1'b1; step(); ird = 1'b0;
    repeat (5) step();
    check("one_pop_reqs", 32'(n_fire), 32'd5);
    check("refill_stall", 32'(imem_req_valid), 32'd0);
    drain();

    // Redirect to 0x100 with two requests held in flight.
    base = n_fire;
    hold = 1'b1; rdy = 1'b1; ird = 1'b1;
    repeat (2) step();
    check("two_inflight", 32'(n_fire - base), 32'd2);
    rdy = 1'b0; redir = 1'b1; redir_pc = 32'h0000_0100;
    step();
    redir = 1'b0; hold = 1'b0; rdy = 1'b1;
    repeat (10) step();
    drain();

    // Redirect in the same cycle as a handshake and a response.
    rdy = 1'b1; ird = 1'b0;
    step();
    redir = 1'b1; redir_pc = 32'h0000_0200;
    step();
    redir = 1'b0;
    check("flush_next_cycle", 32'(if_valid), 32'd0);
    ird = 1'b1;
    repeat (10) step();
    drain();

    // Address wrap at the top of the address space.
    rdy = 1'b1; ird = 1'b1; redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
    step();
    redir = 1'b0;
    repeat (8) step();
    drain();

    // Misaligned redirect target.
    rdy = 1'b1; ird = 1'b1; redir = 1'b1; redir_pc = 32'h0000_0102;
    step();
    redir = 1'b0;
    base = n_fire;
    repeat (6) step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_flag", 32'(fetch_misaligned), 32'd1);
    check("trap_no_reqs", 32'(n_fire - base), 32'd0);
    redir = 1'b1; redir_pc = 32'h0000_0300;
    step();
    redir = 1'b0;
    base = n_fire;
    repeat (6) step();
    check("trap_cleared", 32'(fetch_misaligned), 32'd0);
    check("trap_resumed", 32'(n_fire - base != 0), 32'd1);
`else
    check("realign_reqs", 32'(n_fire - base != 0), 32'd1);
    check("no_trap_flag", 32'(fetch_misaligned), 32'd0);
`endif
    drain();

    // Responses with nothing in flight are ignored.
    rdy = 1'b0; ird = 1'b1; spur = 1'b1;
    repeat (3) step();
    spur = 1'b0;
    step();
    check("spurious_ignored", 32'(if_valid), 32'd0);

    // Reset in the middle of traffic.
    rdy = 1'b1; ird = 1'b0;
    repeat (3) step();
    do_reset();
    rdy = 1'b1; ird = 1'b1;
    repeat (6) step();
    check("post_reset_reqs", 32'(n_fire != 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
